// File: rtl/lrrr_controller.sv
// -----------------------------------------------------------------------------
// lrrr_controller
//
// Command side of the Lrrr boss movement engine. It decides when the boss
// launches (idleN), when the mover flips vertical direction (toggleY), and it
// tracks hits, sequencing the boss through arming, flight, explosion and
// defeat. Runs in the VGA frame domain: all timing is counted in
// startOfFrame pulses.
//
// Ports
//   clk           in   1  system clock
//   resetN        in   1  asynchronous active-low reset
//   startOfFrame  in   1  one-clock pulse per video frame
//   gameStart     in   1  one-clock pulse; starts arming (only honoured in WAIT)
//   hit           in   1  one-clock pulse; player shot collided with boss
//   idleN         out  1  0 = boss parked; rises once to launch the mover
//   toggleY       out  1  one-clock pulse; mover flips vertical speed
//   visible       out  1  boss drawn (ARMING, ACTIVE, DYING)
//   dying         out  1  high throughout DYING (explosion sprite)
//   defeated      out  1  high in DEAD; sticky until reset
//   hitsLeft      out  4  remaining hit points
//   dbgState      out  3  current FSM state (WAIT=0 ARMING=1 ACTIVE=2
//                         DYING=3 DEAD=4), for observation only
//
// All outputs are registered. The status flags (visible/dying/defeated) are
// loaded from the next-state value so they change on the same edge as the
// state itself.
// -----------------------------------------------------------------------------
module lrrr_controller #(
  parameter int          HIT_POINTS         = 5,
  parameter int          START_DELAY_FRAMES = 60,
  parameter int          TOGGLE_MIN_FRAMES  = 20,
  parameter logic [7:0]  TOGGLE_RAND_MASK   = 8'h1F,
  parameter int          INVULN_FRAMES      = 8,
  parameter int          EXPLODE_FRAMES     = 30,
  parameter logic [7:0]  LFSR_SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       hit,
  output logic       idleN,
  output logic       toggleY,
  output logic       visible,
  output logic       dying,
  output logic       defeated,
  output logic [3:0] hitsLeft,
  output logic [2:0] dbgState
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_ARMING = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DYING  = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  // A start delay of 0 behaves as 1 so the arming countdown always terminates.
  localparam logic [9:0] START_LOAD   = (START_DELAY_FRAMES == 0) ? 10'd1
                                                                  : 10'(START_DELAY_FRAMES);
  localparam logic [9:0] TOG_MIN      = 10'(TOGGLE_MIN_FRAMES);
  localparam logic [9:0] INV_LOAD     = 10'(INVULN_FRAMES);
  localparam logic [9:0] EXPLODE_LOAD = 10'(EXPLODE_FRAMES);
  localparam logic [3:0] HP_LOAD      = 4'(HIT_POINTS);

  state_t     state, stateNext;
  logic [9:0] frameCnt, frameCntNext;   // arming delay / explosion length
  logic [9:0] togCnt, togCntNext;       // frames until next toggleY
  logic [9:0] invCnt, invCntNext;       // invulnerability frames left
  logic [7:0] lfsr, lfsrNext;
  logic [3:0] hitsLeftNext;
  logic       idleNNext;
  logic       toggleYNext;
  logic       visibleNext;
  logic       dyingNext;
  logic       defeatedNext;

  logic       lfsrFb;
  logic [9:0] togReload;
  logic       hitCounted;

  // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsrFb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Toggle interval uses the LFSR value before this frame's shift.
  assign togReload = TOG_MIN + {2'b00, (lfsr & TOGGLE_RAND_MASK)};

  // A hit only counts in flight and outside the invulnerability window.
  assign hitCounted = (state == ST_ACTIVE) && hit && (invCnt == 10'd0);

  assign dbgState = state;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext    = state;
    frameCntNext = frameCnt;
    togCntNext   = togCnt;
    invCntNext   = invCnt;
    hitsLeftNext = hitsLeft;
    idleNNext    = idleN;      // sticky once set
    toggleYNext  = 1'b0;
    lfsrNext     = startOfFrame ? {lfsr[6:0], lfsrFb} : lfsr;

    case (state)
      ST_WAIT: begin
        if (gameStart) begin
          stateNext    = ST_ARMING;
          frameCntNext = START_LOAD;
        end
      end

      ST_ARMING: begin
        if (startOfFrame) begin
          if (frameCnt == 10'd1) begin
            stateNext  = ST_ACTIVE;
            idleNNext  = 1'b1;
            togCntNext = togReload;
          end else begin
            frameCntNext = frameCnt - 10'd1;
          end
        end
      end

      ST_ACTIVE: begin
        // Decrement first, then let a counted hit overwrite the load so a hit
        // coinciding with startOfFrame starts a full invulnerability window.
        if (startOfFrame && (invCnt != 10'd0)) begin
          invCntNext = invCnt - 10'd1;
        end
        if (hitCounted) begin
          invCntNext   = INV_LOAD;
          hitsLeftNext = hitsLeft - 4'd1;
        end

        if (hitCounted && (hitsLeft == 4'd1)) begin
          // Killing blow: go straight to the explosion, no toggle this frame.
          stateNext    = ST_DYING;
          frameCntNext = EXPLODE_LOAD;
        end else if (startOfFrame) begin
          if (togCnt == 10'd1) begin
            toggleYNext = 1'b1;
            togCntNext  = togReload;
          end else begin
            togCntNext = togCnt - 10'd1;
          end
        end
      end

      ST_DYING: begin
        if (startOfFrame) begin
          if (frameCnt == 10'd1) begin
            stateNext = ST_DEAD;
          end else begin
            frameCntNext = frameCnt - 10'd1;
          end
        end
      end

      ST_DEAD: begin
        // Terminal until reset.
      end

      default: begin
        stateNext = ST_WAIT;
      end
    endcase

    visibleNext  = (stateNext == ST_ARMING) || (stateNext == ST_ACTIVE) ||
                   (stateNext == ST_DYING);
    dyingNext    = (stateNext == ST_DYING);
    defeatedNext = (stateNext == ST_DEAD);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ST_WAIT;
      frameCnt <= 10'd0;
      togCnt   <= 10'd0;
      invCnt   <= 10'd0;
      lfsr     <= LFSR_SEED;
      hitsLeft <= HP_LOAD;
      idleN    <= 1'b0;
      toggleY  <= 1'b0;
      visible  <= 1'b0;
      dying    <= 1'b0;
      defeated <= 1'b0;
    end else begin
      state    <= stateNext;
      frameCnt <= frameCntNext;
      togCnt   <= togCntNext;
      invCnt   <= invCntNext;
      lfsr     <= lfsrNext;
      hitsLeft <= hitsLeftNext;
      idleN    <= idleNNext;
      toggleY  <= toggleYNext;
      visible  <= visibleNext;
      dying    <= dyingNext;
      defeated <= defeatedNext;
    end
  end

endmodule

// File: tb/tb_lrrr_controller.sv
// -----------------------------------------------------------------------------
// tb_lrrr_controller
//
// Self-checking bench for lrrr_controller with default parameters. A
// frame-level reference model tracks absolute frame numbers (launch frame,
// next toggle frame, end of invulnerability, end of explosion) and is compared
// against every DUT output on every falling clock edge. Directed scenarios add
// hand-computed literal expectations; random phases mix hits and stray
// gameStart pulses.
// -----------------------------------------------------------------------------
module tb_lrrr_controller;

  localparam int FP = 6;  // clocks per video frame

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       gameStart = 1'b0;
  logic       hit = 1'b0;
  logic       idleN, toggleY, visible, dying, defeated;
  logic [3:0] hitsLeft;
  logic [2:0] dbgState;

  always #5 clk = ~clk;

  lrrr_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameStart    (gameStart),
    .hit          (hit),
    .idleN        (idleN),
    .toggleY      (toggleY),
    .visible      (visible),
    .dying        (dying),
    .defeated     (defeated),
    .hitsLeft     (hitsLeft),
    .dbgState     (dbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      if (nMismatched <= 60)
        $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (frame-number based)
  //   phase: 0 wait, 1 arming, 2 flight, 3 exploding, 4 dead
  // ---------------------------------------------------------------------------
  int         mPhase;
  int         sofTotal;     // startOfFrame pulses seen since reset
  logic [7:0] mLfsr;
  int         launchAt;     // sofTotal value at which the boss launches
  int         nextTog;      // sofTotal value of the next toggle
  int         invUntil;     // hits count once sofTotal (before the hit) >= this
  int         deadAt;       // sofTotal value at which the explosion ends
  int         mHits;
  logic       mIdle;
  logic       mTog;

  // Compare-process bookkeeping
  logic       prevTogDut;
  int         lastTogSof;
  int         togCount;
  logic       checkEn = 1'b0;

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    int ones;
    ones = 0;
    // taps at bit positions 7,5,4,3 (x^8, x^6, x^5, x^4)
    if (v[7]) ones++;
    if (v[5]) ones++;
    if (v[4]) ones++;
    if (v[3]) ones++;
    return 8'(((int'(v) * 2) % 256) + (ones % 2));
  endfunction

  function automatic int togInterval(input logic [7:0] v);
    return 20 + (int'(v) % 32);
  endfunction

  task automatic modelReset();
    mPhase     = 0;
    sofTotal   = 0;
    mLfsr      = 8'hA5;
    launchAt   = 0;
    nextTog    = 0;
    invUntil   = 0;
    deadAt     = 0;
    mHits      = 5;
    mIdle      = 1'b0;
    mTog       = 1'b0;
    prevTogDut = 1'b0;
    lastTogSof = -1;
  endtask

  task automatic modelStep(input logic s, input logic g, input logic h);
    int         prevTot;
    int         newTot;
    logic [7:0] pre;
    logic       tog;
    prevTot = sofTotal;
    newTot  = sofTotal + (s ? 1 : 0);
    pre     = mLfsr;
    tog     = 1'b0;
    case (mPhase)
      0: if (g) begin
           mPhase   = 1;
           launchAt = newTot + 60;
         end
      1: if (s && newTot == launchAt) begin
           mPhase  = 2;
           mIdle   = 1'b1;
           nextTog = newTot + togInterval(pre);
         end
      2: begin
           if (h && prevTot >= invUntil) begin
             mHits    = mHits - 1;
             invUntil = newTot + 8;
             if (mHits == 0) begin
               mPhase = 3;
               deadAt = newTot + 30;
             end
           end
           if (mPhase == 2 && s && newTot == nextTog) begin
             tog     = 1'b1;
             nextTog = newTot + togInterval(pre);
           end
         end
      3: if (s && newTot == deadAt) mPhase = 4;
      default: ;
    endcase
    if (s) mLfsr = lfsrStep(mLfsr);
    sofTotal = newTot;
    mTog     = tog;
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge, DUT against model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (checkEn) begin
      check("idleN",    32'(idleN),    32'(mIdle));
      check("toggleY",  32'(toggleY),  32'(mTog));
      check("visible",  32'(visible),  32'(mPhase >= 1 && mPhase <= 3));
      check("dying",    32'(dying),    32'(mPhase == 3));
      check("defeated", 32'(defeated), 32'(mPhase == 4));
      check("hitsLeft", 32'(hitsLeft), 32'(mHits));
      if (toggleY === 1'b1) begin
        togCount++;
        check("toggle_width", 32'(prevTogDut), 32'd0);
        if (lastTogSof >= 0)
          check("toggle_gap_range",
                32'((sofTotal - lastTogSof) >= 20 && (sofTotal - lastTogSof) <= 51), 32'd1);
        lastTogSof = sofTotal;
      end
      prevTogDut = toggleY;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic s, input logic g, input logic h);
    startOfFrame = s;
    gameStart    = g;
    hit          = h;
    @(posedge clk);
    if (resetN) modelStep(s, g, h);
    else        modelReset();
    #1;
    startOfFrame = 1'b0;
    gameStart    = 1'b0;
    hit          = 1'b0;
  endtask

  // One frame; hitOff = clock offset of a hit pulse (0 = with startOfFrame), -1 none
  task automatic frame(input int hitOff);
    for (int c = 0; c < FP; c++) step(c == 0, 1'b0, c == hitOff);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) frame(-1);
  endtask

  task automatic randomFrames(input int n, input int hitDen);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < FP; c++)
        step(c == 0, $urandom_range(0, 99) == 0, $urandom_range(0, hitDen - 1) == 0);
  endtask

  task automatic enterReset();
    resetN = 1'b0;
    modelReset();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    togCount = 0;
    modelReset();
    checkEn = 1'b1;

    // Model pins: first LFSR steps from the seed, hand-computed
    check("lfsr_pin0", 32'(lfsrStep(8'hA5)), 32'h4A);
    check("lfsr_pin1", 32'(lfsrStep(8'h4A)), 32'h95);
    check("interval_pin", 32'(togInterval(8'hA5)), 32'd25);

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("reset_hitsLeft", 32'(hitsLeft), 32'd5);
    check("reset_idleN",    32'(idleN),    32'd0);
    check("reset_visible",  32'(visible),  32'd0);
    resetN = 1'b1;

    // 1: 100 frames without gameStart, random hits
    togCount = 0;
    for (int f = 0; f < 100; f++) frame($urandom_range(0, 1) == 1 ? int'($urandom_range(0, FP - 1)) : -1);
    check("t1_idleN",    32'(idleN),    32'd0);
    check("t1_visible",  32'(visible),  32'd0);
    check("t1_hitsLeft", 32'(hitsLeft), 32'd5);
    check("t1_noToggle", 32'(togCount), 32'd0);

    // 2: arming delay
    step(1'b0, 1'b1, 1'b0);
    check("t2_visible_after_start", 32'(visible), 32'd1);
    check("t2_idle_after_start",    32'(idleN),   32'd0);
    frames(59);
    check("t2_idle_after_59", 32'(idleN), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("t2_idle_after_60", 32'(idleN), 32'd1);
    repeat (FP - 1) step(1'b0, 1'b0, 1'b0);

    // 3: 300 frames of flight
    togCount = 0;
    frames(300);
    check("t3_toggles_seen", 32'(togCount >= 5), 32'd1);

    // 4: five hits ten frames apart, then explosion
    for (int k = 0; k < 5; k++) begin
      frame(2);
      check("t4_hitsLeft", 32'(hitsLeft), 32'(4 - k));
      if (k < 4) frames(9);
    end
    togCount = 0;
    cnt = 0;
    for (int f = 0; f < 40 && defeated !== 1'b1; f++) begin
      if (dying === 1'b1) cnt++;
      frame(-1);
    end
    check("t4_dying_frames", 32'(cnt),      32'd30);
    check("t4_defeated",     32'(defeated), 32'd1);
    check("t4_visible",      32'(visible),  32'd0);
    check("t4_dying_off",    32'(dying),    32'd0);
    check("t4_noToggle",     32'(togCount), 32'd0);

    // 5: invulnerability window
    enterReset();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    frames(60);
    frame(2);
    check("t5_first_hit", 32'(hitsLeft), 32'd4);
    frames(2);
    frame(2);
    check("t5_hit_3_frames", 32'(hitsLeft), 32'd4);
    frames(4);
    frame(0);
    check("t5_hit_with_sof", 32'(hitsLeft), 32'd4);
    frame(2);
    check("t5_hit_9_frames", 32'(hitsLeft), 32'd3);

    // Random flight with hits and stray gameStart pulses
    randomFrames(150, 25);

    // 6a: reset mid-ARMING
    enterReset();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    frames(20);
    step(1'b0, 1'b0, 1'b0);
    enterReset();
    @(negedge clk);
    check("t6a_visible", 32'(visible), 32'd0);
    for (int i = 0; i < 4; i++) step(i[0], 1'b1, 1'b1);
    check("t6a_hold_visible",  32'(visible),  32'd0);
    check("t6a_hold_hitsLeft", 32'(hitsLeft), 32'd5);
    resetN = 1'b1;

    // 6b: reset mid-DYING
    step(1'b0, 1'b1, 1'b0);
    frames(60);
    for (int k = 0; k < 5; k++) begin
      frame(2);
      frames(8);
    end
    frames(2);
    check("t6b_dying_before_reset", 32'(dying), 32'd1);
    enterReset();
    @(negedge clk);
    check("t6b_dying",    32'(dying),    32'd0);
    check("t6b_hitsLeft", 32'(hitsLeft), 32'd5);
    check("t6b_idleN",    32'(idleN),    32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    resetN = 1'b1;

    // Final random game
    step(1'b0, 1'b1, 1'b0);
    randomFrames(260, 30);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
